// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM burst reader.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry output FIFO with a registered head word.
module ram_rd_fifo
    import ram_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == 2'(FIFO_DEPTH));
    assign empty   = (count_q == 2'd0);
    assign head    = head_q;
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (empty) head_q <= din;
                    else       tail_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Burst read master for a single-port synchronous RAM with a valid/ready output stream.
module ram_reader
    import ram_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam logic [ADDR_WIDTH:0] RemOne = (ADDR_WIDTH + 1)'(1);

    rd_state_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  inflight_q;
    logic                  busy_q;
    logic                  done_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    logic       pop;
    logic       credit_ok;
    logic       drain_done;

    ram_rd_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight_q),
        .din  (ram_data),
        .pop  (pop),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (m_data),
        .count(fifo_count)
    );

    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    // occupancy + inflight - pop < 2, rearranged to avoid unsigned underflow.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign ram_re    = (state_q == StRead) && (remaining_q != '0) && credit_ok;
    assign ram_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // True when the FIFO will be empty next cycle with nothing left in flight.
    assign drain_done = (state_q == StDrain) && !inflight_q &&
                        (fifo_empty || (!fifo_full && pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= ram_re;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q      <= base_addr;
                            remaining_q <= length;
                            busy_q      <= 1'b1;
                            state_q     <= StRead;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (ram_re) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - RemOne;
                        if (remaining_q == RemOne) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// Scoreboard bench for ram_reader driving a behavioural one-cycle-latency RAM.
module tb_ram_reader;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_re, m_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, m_data;
    logic          m_ready = 1'b1;

    ram_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_re) ram_data <= mem[ram_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] w;
    logic [AW-1:0] exp_addr = '0;
    int            exp_len = 0;
    int            issued_cnt = 0;
    int            hs_cnt = 0;
    int            done_cnt = 0;
    int            outstanding = 0;
    int            max_out = 0;
    int            stall_cycles = 0;
    bit            last_hs_prev = 1'b0;
    bit            zero_len_pending = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (outstanding > max_out) max_out = outstanding;
            if (done) begin
                done_cnt++;
                check("done_after_last", 32'(last_hs_prev | zero_len_pending), 1);
                check("busy_at_done", 32'(busy), 0);
                zero_len_pending = 1'b0;
            end
            last_hs_prev = 1'b0;
            if (ram_re) begin
                check("ram_addr", 32'(ram_addr), 32'(exp_addr));
                exp_addr = exp_addr + 1'b1;
                issued_cnt++;
                outstanding++;
                if (issued_cnt > exp_len) check("extra_read", issued_cnt, exp_len);
            end else if (busy && issued_cnt < exp_len) begin
                stall_cycles++;
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                outstanding--;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(w));
                    last_hs_prev = (exp_q.size() == 0);
                end
            end
        end
    end

    // m_ready: 0 = always high, 1 = 1,0,0,1,0,1 pattern
    int       ready_mode = 0;
    int       pat_idx = 0;
    bit [5:0] pat = 6'b100101;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                m_ready = pat[5 - (pat_idx % 6)];
                pat_idx++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = n;
        a = b;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[a]);
            a = a + 1'b1;
        end
        exp_addr = b;
        exp_len = int'(n);
        issued_cnt = 0;
        stall_cycles = 0;
        max_out = 0;
        if (n == '0) zero_len_pending = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(posedge clk);
            if (done_cnt > d0) seen = 1'b1;
        end
        check("done_seen", done_cnt, d0 + 1);
    endtask

    initial begin
        int h0;
        int d0;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int d0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        #2;
        check("reset_outputs", 32'({busy, done, ram_re, ram_addr, m_valid, m_data}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: basic burst and first-word latency
        for (int i = 0; i <= 10; i++) mem[i] = DW'(i + 1);
        h0 = hs_cnt;
        launch(11'd0, 12'd11);
        @(negedge clk);
        check("c1_ram_re", 32'(ram_re), 1);
        check("c1_busy", 32'(busy), 1);
        @(negedge clk);
        check("c2_m_valid", 32'(m_valid), 0);
        @(negedge clk);
        check("c3_m_valid", 32'(m_valid), 1);
        check("c3_m_data", 32'(m_data), 1);
        wait_done(100);
        check("t1_words", hs_cnt - h0, 11);
        check("t1_no_stall", stall_cycles, 0);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 0);

        // 2: address wrap
        mem[2046] = 8'hA0; mem[2047] = 8'hB1; mem[0] = 8'hC2; mem[1] = 8'hD3;
        h0 = hs_cnt;
        launch(11'd2046, 12'd4);
        wait_done(100);
        check("t2_words", hs_cnt - h0, 4);

        // 3: back-pressure
        ready_mode = 1;
        h0 = hs_cnt;
        launch(11'd20, 12'd5);
        wait_done(200);
        check("t3_words", hs_cnt - h0, 5);
        check("t3_max_occupancy", 32'(max_out <= 2), 1);
        check("t3_stalled", 32'(stall_cycles > 0), 1);
        ready_mode = 0;

        // 4: zero length, then start while busy
        d0 = done_cnt;
        launch(11'd7, 12'd0);
        @(negedge clk);
        check("t4_zero_re", 32'(ram_re), 0);
        check("t4_zero_busy", 32'(busy), 0);
        @(posedge clk);
        check("t4_zero_done", done_cnt, d0 + 1);
        check("t4_zero_reads", issued_cnt, 0);
        h0 = hs_cnt;
        launch(11'd5, 12'd3);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 11'd100; length = 12'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100);
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        check("t4_words", hs_cnt - h0, 3);
        check("t4_reads", issued_cnt, 3);
        check("t4_no_extra_done", done_cnt, d0);

        // 5: reset while the third of 8 words is in flight
        launch(11'd0, 12'd8);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", 32'({busy, done, ram_re, ram_addr, m_valid, m_data}), 0);
        exp_q.delete();
        outstanding = 0;
        last_hs_prev = 1'b0;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("t5_no_done", done_cnt, d0);
        h0 = hs_cnt;
        launch(11'd0, 12'd2);
        wait_done(100);
        check("t5_words", hs_cnt - h0, 2);

        // 6: full-depth burst
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        h0 = hs_cnt;
        launch(11'd0, 12'd2048);
        wait_done(2300);
        check("t6_words", hs_cnt - h0, 2048);
        check("t6_reads", issued_cnt, 2048);
        check("t6_addr_wrap", 32'(ram_addr), 0);
        check("t6_sb_empty", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
